vga_frame_scheduler: RTL and testbench

//  Owns the single VGA adapter write port and sequences the pixel engines that share it once per frame.
//  On each frame tick it runs three phases in order: screen clear, then tile draw, then an optional overlay.

---
 rtl/vga_frame_scheduler.sv | 124 ++++++++++++
 tb/tb_vga_frame_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_scheduler.sv
// vga_frame_scheduler: per-frame CLEAR -> TILE -> optional OVERLAY sequencer that owns the vga_adapter port,
// with per-phase watchdog and saturating timeout/overrun counters.
module vga_frame_scheduler #(
    parameter int          X_W     = 8,
    parameter int          Y_W     = 7,
    parameter int          C_W     = 24,
    parameter logic [19:0] TIMEOUT = 20'd800000
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           frame_tick,
    input  logic           overlay_en,
    output logic           clr_start,
    input  logic           clr_done,
    input  logic [X_W-1:0] clr_x,
    input  logic [Y_W-1:0] clr_y,
    input  logic [C_W-1:0] clr_c,
    input  logic           clr_plot,
    output logic           tile_start,
    input  logic           tile_done,
    input  logic [X_W-1:0] tile_x,
    input  logic [Y_W-1:0] tile_y,
    input  logic [C_W-1:0] tile_c,
    input  logic           tile_plot,
    output logic           ovl_start,
    input  logic           ovl_done,
    input  logic [X_W-1:0] ovl_x,
    input  logic [Y_W-1:0] ovl_y,
    input  logic [C_W-1:0] ovl_c,
    input  logic           ovl_plot,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [C_W-1:0] vga_colour,
    output logic           vga_plot,
    output logic [1:0]     phase,
    output logic           frame_done,
    output logic [7:0]     timeout_cnt,
    output logic [7:0]     overrun_cnt
);
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_CLR = 2'b01, S_TILE = 2'b10, S_OVL = 2'b11} state_t;

    state_t         r_state;
    logic [19:0]    r_cnt;
    logic           w_done;
    logic           w_done_ok;
    logic           w_wd;
    logic           w_exit;
    logic           w_abort;
    logic           w_drop;
    logic           w_load;
    logic           w_plot;
    logic [X_W-1:0] w_x;
    logic [Y_W-1:0] w_y;
    logic [C_W-1:0] w_c;

    assign phase  = r_state;
    assign w_done = (r_state == S_CLR) ? clr_done : (r_state == S_TILE) ? tile_done : (r_state == S_OVL) ? ovl_done : 1'b0;
    assign w_plot = (r_state == S_CLR) ? clr_plot : (r_state == S_TILE) ? tile_plot : (r_state == S_OVL) ? ovl_plot : 1'b0;
    assign w_x    = (r_state == S_CLR) ? clr_x : (r_state == S_TILE) ? tile_x : ovl_x;
    assign w_y    = (r_state == S_CLR) ? clr_y : (r_state == S_TILE) ? tile_y : ovl_y;
    assign w_c    = (r_state == S_CLR) ? clr_c : (r_state == S_TILE) ? tile_c : ovl_c;

    // r_cnt is zero exactly on the start-pulse cycle, where done is not yet trusted
    assign w_done_ok = w_done && (r_cnt != 20'd0);
    assign w_wd      = (r_state != S_IDLE) && (r_cnt == TIMEOUT - 20'd1);
    assign w_exit    = w_done_ok || w_wd;
    assign w_abort   = w_wd && !w_done_ok;
    assign w_drop    = frame_tick && ((r_state != S_IDLE) || frame_done);
    // the exit cycle's pixel would land in the next phase's first cycle, so it is suppressed
    assign w_load    = (r_state != S_IDLE) && !w_exit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            clr_start   <= 1'b0;
            tile_start  <= 1'b0;
            ovl_start   <= 1'b0;
            frame_done  <= 1'b0;
            timeout_cnt <= '0;
            overrun_cnt <= '0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_plot    <= 1'b0;
        end else begin
            clr_start   <= 1'b0;
            tile_start  <= 1'b0;
            ovl_start   <= 1'b0;
            frame_done  <= 1'b0;
            r_cnt       <= (r_state == S_IDLE) ? 20'd0 : r_cnt + 20'd1;
            timeout_cnt <= timeout_cnt + {7'd0, w_abort && (timeout_cnt != 8'hFF)};
            overrun_cnt <= overrun_cnt + {7'd0, w_drop && (overrun_cnt != 8'hFF)};
            vga_plot    <= w_load && w_plot;
            if (w_load) begin
                vga_x      <= w_x;
                vga_y      <= w_y;
                vga_colour <= w_c;
            end
            case (r_state)
                S_IDLE: if (frame_tick && !frame_done) begin
                    r_state   <= S_CLR;
                    clr_start <= 1'b1;
                end
                S_CLR: if (w_exit) begin
                    r_state    <= S_TILE;
                    tile_start <= 1'b1;
                    r_cnt      <= '0;
                end
                S_TILE: if (w_exit) begin
                    r_state    <= overlay_en ? S_OVL : S_IDLE;
                    ovl_start  <= overlay_en;
                    frame_done <= !overlay_en;
                    r_cnt      <= '0;
                end
                default: if (w_exit) begin
                    r_state    <= S_IDLE;
                    frame_done <= 1'b1;
                    r_cnt      <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vga_frame_scheduler.sv
// tb_vga_frame_scheduler: scenario tasks for the frame scheduler; u_a uses the default watchdog, u_b a 16-cycle one.
module tb_vga_frame_scheduler;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic ft_a = 1'b0, ft_b = 1'b0, overlay_en = 1'b0;
    logic clr_done = 1'b0, tile_done = 1'b0, ovl_done = 1'b0;
    logic clr_plot = 1'b0, tile_plot = 1'b0, ovl_plot = 1'b0;
    logic [7:0] clr_x = '0, tile_x = '0, ovl_x = '0;
    logic [6:0] clr_y = '0, tile_y = '0, ovl_y = '0;
    logic [23:0] clr_c = '0, tile_c = '0, ovl_c = '0;

    logic a_clr_start, a_tile_start, a_ovl_start, a_vga_plot, a_frame_done;
    logic [7:0] a_vga_x, a_timeout_cnt, a_overrun_cnt;
    logic [6:0] a_vga_y;
    logic [23:0] a_vga_colour;
    logic [1:0] a_phase;
    logic b_clr_start, b_tile_start, b_ovl_start, b_vga_plot, b_frame_done;
    logic [7:0] b_vga_x, b_timeout_cnt, b_overrun_cnt;
    logic [6:0] b_vga_y;
    logic [23:0] b_vga_colour;
    logic [1:0] b_phase;

    int checks = 0, failures = 0;
    int a_fd_n = 0, a_ovl_n = 0, a_start_n = 0;
    logic [38:0] pix_q[$];
    logic [1:0]  ph_q[$];
    logic [1:0]  last_phase = 2'b00;

    always #5 clk = ~clk;

    vga_frame_scheduler u_a (
        .clk(clk), .resetn(resetn), .frame_tick(ft_a), .overlay_en(overlay_en),
        .clr_start(a_clr_start), .clr_done(clr_done), .clr_x(clr_x), .clr_y(clr_y), .clr_c(clr_c), .clr_plot(clr_plot),
        .tile_start(a_tile_start), .tile_done(tile_done), .tile_x(tile_x), .tile_y(tile_y), .tile_c(tile_c), .tile_plot(tile_plot),
        .ovl_start(a_ovl_start), .ovl_done(ovl_done), .ovl_x(ovl_x), .ovl_y(ovl_y), .ovl_c(ovl_c), .ovl_plot(ovl_plot),
        .vga_x(a_vga_x), .vga_y(a_vga_y), .vga_colour(a_vga_colour), .vga_plot(a_vga_plot),
        .phase(a_phase), .frame_done(a_frame_done), .timeout_cnt(a_timeout_cnt), .overrun_cnt(a_overrun_cnt));

    vga_frame_scheduler #(.TIMEOUT(20'd16)) u_b (
        .clk(clk), .resetn(resetn), .frame_tick(ft_b), .overlay_en(overlay_en),
        .clr_start(b_clr_start), .clr_done(clr_done), .clr_x(clr_x), .clr_y(clr_y), .clr_c(clr_c), .clr_plot(clr_plot),
        .tile_start(b_tile_start), .tile_done(tile_done), .tile_x(tile_x), .tile_y(tile_y), .tile_c(tile_c), .tile_plot(tile_plot),
        .ovl_start(b_ovl_start), .ovl_done(ovl_done), .ovl_x(ovl_x), .ovl_y(ovl_y), .ovl_c(ovl_c), .ovl_plot(ovl_plot),
        .vga_x(b_vga_x), .vga_y(b_vga_y), .vga_colour(b_vga_colour), .vga_plot(b_vga_plot),
        .phase(b_phase), .frame_done(b_frame_done), .timeout_cnt(b_timeout_cnt), .overrun_cnt(b_overrun_cnt));

    // scoreboard side: pixels and phase changes of u_a are popped as they appear
    always @(negedge clk) begin
        logic [38:0] p;
        logic [1:0]  e;
        if (a_vga_plot) begin
            checks++;
            if (pix_q.size() == 0) begin
                failures++;
                $display("FAIL sb_pixel unexpected plot got=(%0d,%0d,%h) required=none", a_vga_x, a_vga_y, a_vga_colour);
            end else begin
                p = pix_q.pop_front();
                if ({a_vga_x, a_vga_y, a_vga_colour} !== p) begin
                    failures++;
                    $display("FAIL sb_pixel got=%h required=%h", {a_vga_x, a_vga_y, a_vga_colour}, p);
                end
            end
        end
        if (a_phase !== last_phase) begin
            checks++;
            if (ph_q.size() == 0) begin
                failures++;
                $display("FAIL sb_phase unexpected change got=%0d required=none", a_phase);
            end else begin
                e = ph_q.pop_front();
                if (a_phase !== e) begin
                    failures++;
                    $display("FAIL sb_phase got=%0d required=%0d", a_phase, e);
                end
            end
            last_phase = a_phase;
        end
        checks++;
        if ((32'(a_clr_start) + 32'(a_tile_start) + 32'(a_ovl_start) > 1) || (32'(b_clr_start) + 32'(b_tile_start) + 32'(b_ovl_start) > 1)) begin
            failures++;
            $display("FAIL start_overlap got a=%b%b%b b=%b%b%b required=one-hot", a_clr_start, a_tile_start, a_ovl_start, b_clr_start, b_tile_start, b_ovl_start);
        end
        a_fd_n += 32'(a_frame_done);
        a_ovl_n += 32'(a_ovl_start);
        a_start_n += 32'(a_clr_start | a_tile_start | a_ovl_start);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step(3);
        checks++;
        if ({a_clr_start, a_tile_start, a_ovl_start, a_vga_x, a_vga_y, a_vga_colour, a_vga_plot, a_phase, a_frame_done, a_timeout_cnt, a_overrun_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_a got phase=%0d plot=%b to=%0d ov=%0d required=all-zero", a_phase, a_vga_plot, a_timeout_cnt, a_overrun_cnt);
        end
        checks++;
        if ({b_clr_start, b_tile_start, b_ovl_start, b_vga_x, b_vga_y, b_vga_colour, b_vga_plot, b_phase, b_frame_done, b_timeout_cnt, b_overrun_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_b got phase=%0d plot=%b to=%0d ov=%0d required=all-zero", b_phase, b_vga_plot, b_timeout_cnt, b_overrun_cnt);
        end
        resetn = 1'b1;
        step(2);
    endtask

    task automatic test_sequence();
        int fd0, ov0;
        fd0 = a_fd_n;
        ov0 = a_ovl_n;
        ph_q.push_back(2'b01); ph_q.push_back(2'b10); ph_q.push_back(2'b00);
        ft_a = 1'b1; step(1); ft_a = 1'b0;
        checks++; if (a_clr_start !== 1'b1 || a_phase !== 2'b01) begin failures++; $display("FAIL t1_clr_start got start=%b phase=%0d required=1,1", a_clr_start, a_phase); end
        clr_done = 1'b1; step(1); clr_done = 1'b0;
        checks++; if (a_phase !== 2'b01 || a_clr_start !== 1'b0) begin failures++; $display("FAIL t1_early_done got phase=%0d start=%b required=1,0", a_phase, a_clr_start); end
        step(98);
        clr_done = 1'b1; step(1); clr_done = 1'b0;
        checks++; if (a_phase !== 2'b10 || a_tile_start !== 1'b1) begin failures++; $display("FAIL t1_tile got phase=%0d start=%b required=2,1", a_phase, a_tile_start); end
        step(49);
        tile_done = 1'b1; step(1); tile_done = 1'b0;
        checks++; if (a_phase !== 2'b00 || a_frame_done !== 1'b1) begin failures++; $display("FAIL t1_idle got phase=%0d fd=%b required=0,1", a_phase, a_frame_done); end
        step(1);
        checks++; if (a_frame_done !== 1'b0 || a_fd_n - fd0 != 1) begin failures++; $display("FAIL t1_frame_done got fd=%b pulses=%0d required=0,1", a_frame_done, a_fd_n - fd0); end
        checks++; if (a_ovl_n != ov0) begin failures++; $display("FAIL t1_no_ovl got=%0d required=%0d", a_ovl_n, ov0); end
        step(2);
    endtask

    task automatic test_mux();
        ph_q.push_back(2'b01); ph_q.push_back(2'b10); ph_q.push_back(2'b00);
        ft_a = 1'b1; step(1); ft_a = 1'b0;
        clr_plot = 1'b1; clr_x = 8'd5; clr_y = 7'd9; clr_c = 24'hFF0000;
        tile_plot = 1'b1; tile_x = 8'd77; tile_y = 7'd66; tile_c = 24'h00FF00;
        pix_q.push_back({8'd5, 7'd9, 24'hFF0000});
        step(1);
        checks++; if ({a_vga_plot, a_vga_x, a_vga_y, a_vga_colour} !== {1'b1, 8'd5, 7'd9, 24'hFF0000}) begin failures++; $display("FAIL t2_pixel got=(%0d,%0d,%h,%b) required=(5,9,ff0000,1)", a_vga_x, a_vga_y, a_vga_colour, a_vga_plot); end
        clr_x = 8'd6; clr_c = 24'h123456; clr_done = 1'b1;
        step(1);
        clr_done = 1'b0; clr_plot = 1'b0; tile_plot = 1'b0;
        checks++; if ({a_phase, a_vga_plot, a_vga_x, a_vga_colour} !== {2'b10, 1'b0, 8'd5, 24'hFF0000}) begin failures++; $display("FAIL t2_first_cycle got phase=%0d plot=%b x=%0d c=%h required=2,0,5,ff0000", a_phase, a_vga_plot, a_vga_x, a_vga_colour); end
        step(1);
        tile_done = 1'b1; step(1); tile_done = 1'b0;
        checks++; if (a_phase !== 2'b00) begin failures++; $display("FAIL t2_idle got=%0d required=0", a_phase); end
        step(2);
    endtask

    task automatic test_watchdog();
        ft_b = 1'b1; step(1); ft_b = 1'b0;
        step(15);
        checks++; if (b_phase !== 2'b01 || b_timeout_cnt !== 8'd0) begin failures++; $display("FAIL t3_before got phase=%0d to=%0d required=1,0", b_phase, b_timeout_cnt); end
        step(1);
        checks++; if (b_phase !== 2'b10 || b_tile_start !== 1'b1 || b_timeout_cnt !== 8'd1) begin failures++; $display("FAIL t3_abort got phase=%0d start=%b to=%0d required=2,1,1", b_phase, b_tile_start, b_timeout_cnt); end
        step(1);
        tile_done = 1'b1; step(1); tile_done = 1'b0;
        checks++; if (b_phase !== 2'b00 || b_timeout_cnt !== 8'd1) begin failures++; $display("FAIL t3_idle got phase=%0d to=%0d required=0,1", b_phase, b_timeout_cnt); end
        step(2);
    endtask

    task automatic test_overrun();
        ph_q.push_back(2'b01); ph_q.push_back(2'b10); ph_q.push_back(2'b00);
        ft_a = 1'b1; step(1); ft_a = 1'b0;
        step(1); clr_done = 1'b1; step(1); clr_done = 1'b0;
        ft_a = 1'b1; step(1); ft_a = 1'b0;
        checks++; if (a_overrun_cnt !== 8'd1 || a_phase !== 2'b10) begin failures++; $display("FAIL t4_first got ov=%0d phase=%0d required=1,2", a_overrun_cnt, a_phase); end
        tile_done = 1'b1; step(1); tile_done = 1'b0;
        ft_a = 1'b1; step(1); ft_a = 1'b0;
        checks++; if (a_phase !== 2'b00 || a_overrun_cnt !== 8'd2 || a_clr_start !== 1'b0) begin failures++; $display("FAIL t4_fd_tick got phase=%0d ov=%0d start=%b required=0,2,0", a_phase, a_overrun_cnt, a_clr_start); end
        ph_q.push_back(2'b01); ph_q.push_back(2'b10); ph_q.push_back(2'b00);
        ft_a = 1'b1; step(1);
        checks++; if (a_phase !== 2'b01 || a_overrun_cnt !== 8'd2) begin failures++; $display("FAIL t4_accept got phase=%0d ov=%0d required=1,2", a_phase, a_overrun_cnt); end
        step(300); ft_a = 1'b0;
        checks++; if (a_overrun_cnt !== 8'd255 || a_phase !== 2'b01) begin failures++; $display("FAIL t4_saturate got ov=%0d phase=%0d required=255,1", a_overrun_cnt, a_phase); end
        clr_done = 1'b1; step(1); clr_done = 1'b0;
        step(1); tile_done = 1'b1; step(1); tile_done = 1'b0;
        checks++; if (a_phase !== 2'b00 || a_overrun_cnt !== 8'd255) begin failures++; $display("FAIL t4_end got phase=%0d ov=%0d required=0,255", a_phase, a_overrun_cnt); end
        step(2);
    endtask

    task automatic test_done_vs_watchdog();
        overlay_en = 1'b1;
        ft_b = 1'b1; step(1); ft_b = 1'b0;
        step(1); clr_done = 1'b1; step(1); clr_done = 1'b0;
        step(1); tile_done = 1'b1; step(1); tile_done = 1'b0;
        overlay_en = 1'b0;
        checks++; if (b_phase !== 2'b11 || b_ovl_start !== 1'b1) begin failures++; $display("FAIL t5_ovl got phase=%0d start=%b required=3,1", b_phase, b_ovl_start); end
        step(15);
        checks++; if (b_phase !== 2'b11) begin failures++; $display("FAIL t5_hold got=%0d required=3", b_phase); end
        ovl_done = 1'b1; step(1); ovl_done = 1'b0;
        checks++; if (b_phase !== 2'b00 || b_frame_done !== 1'b1 || b_timeout_cnt !== 8'd1) begin failures++; $display("FAIL t5_tie got phase=%0d fd=%b to=%0d required=0,1,1", b_phase, b_frame_done, b_timeout_cnt); end
        step(1);
        checks++; if (b_frame_done !== 1'b0) begin failures++; $display("FAIL t5_fd_once got=%b required=0", b_frame_done); end
        step(2);
    endtask

    task automatic test_reset_mid_phase();
        int fd0, s0;
        ph_q.push_back(2'b01); ph_q.push_back(2'b10); ph_q.push_back(2'b00);
        ft_a = 1'b1; step(1); ft_a = 1'b0;
        step(1); clr_done = 1'b1; step(1); clr_done = 1'b0;
        tile_plot = 1'b1; tile_x = 8'd12; tile_y = 7'd34; tile_c = 24'h00ABCD;
        pix_q.push_back({8'd12, 7'd34, 24'h00ABCD});
        step(1);
        checks++; if (a_vga_plot !== 1'b1 || a_phase !== 2'b10) begin failures++; $display("FAIL t6_plotting got plot=%b phase=%0d required=1,2", a_vga_plot, a_phase); end
        fd0 = a_fd_n;
        #6 resetn = 1'b0;
        #1;
        checks++; if (a_vga_plot !== 1'b0 || a_phase !== 2'b00) begin failures++; $display("FAIL t6_async got plot=%b phase=%0d required=0,0", a_vga_plot, a_phase); end
        tile_plot = 1'b0;
        s0 = a_start_n;
        step(2);
        resetn = 1'b1;
        step(5);
        checks++; if (a_start_n != s0 || a_phase !== 2'b00 || a_fd_n != fd0 || a_overrun_cnt !== 8'd0) begin failures++; $display("FAIL t6_after got starts=%0d phase=%0d fd=%0d ov=%0d required=%0d,0,%0d,0", a_start_n, a_phase, a_fd_n, a_overrun_cnt, s0, fd0); end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_mux();
        test_watchdog();
        test_overrun();
        test_done_vs_watchdog();
        test_reset_mid_phase();
        checks++;
        if (pix_q.size() != 0 || ph_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got pix=%0d phase=%0d required=0,0", pix_q.size(), ph_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
